// File: rtl/note_glyph_pkg.sv
// Shared glyph codes and renderer FSM states for the note display path.
package note_glyph_pkg;

   localparam logic [3:0] GLYPH_BLANK = 4'd0;
   localparam logic [3:0] GLYPH_A     = 4'd1;
   localparam logic [3:0] GLYPH_B     = 4'd2;
   localparam logic [3:0] GLYPH_C     = 4'd3;
   localparam logic [3:0] GLYPH_D     = 4'd4;
   localparam logic [3:0] GLYPH_E     = 4'd5;
   localparam logic [3:0] GLYPH_F     = 4'd6;
   localparam logic [3:0] GLYPH_G     = 4'd7;
   localparam logic [3:0] GLYPH_SHARP = 4'd8;
   localparam logic [3:0] GLYPH_D1    = 4'd9;
   localparam logic [3:0] GLYPH_D2    = 4'd10;
   localparam logic [3:0] GLYPH_D3    = 4'd11;
   localparam logic [3:0] GLYPH_D4    = 4'd12;

   localparam int unsigned FONT_W = 12;
   localparam int unsigned FONT_H = 12;

   typedef enum logic [1:0] {
      S_WIPE,
      S_IDLE,
      S_DRAW,
      S_DONE
   } state_e;

endpackage

// File: rtl/note_glyph_renderer_glyph_rom.sv
// 12x12 note font: combinational (code, row) -> row bitmap, MSB is the leftmost column.
module glyph_rom
   import note_glyph_pkg::*;
#(
   parameter int unsigned GLYPH_W = 12,
   parameter int unsigned GLYPH_H = 12,
   parameter int unsigned CODE_W  = 4
) (
   input  logic [CODE_W-1:0]          code_i,
   input  logic [$clog2(GLYPH_H)-1:0] row_i,
   output logic [GLYPH_W-1:0]         row_bits_o
);

   localparam int unsigned ROW_W = $clog2(GLYPH_H);

   logic [0:FONT_H-1][FONT_W-1:0] font;

   always_comb begin
      case (code_i)
         GLYPH_A:     font = {12'h000, 12'h0F0, 12'h198, 12'h30C, 12'h30C, 12'h3FC,
                              12'h3FC, 12'h30C, 12'h30C, 12'h30C, 12'h30C, 12'h000};
         GLYPH_B:     font = {12'h000, 12'h3F0, 12'h318, 12'h318, 12'h318, 12'h3F0,
                              12'h3F0, 12'h318, 12'h318, 12'h318, 12'h3F0, 12'h000};
         GLYPH_C:     font = {12'h000, 12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h300,
                              12'h300, 12'h300, 12'h300, 12'h18C, 12'h0F8, 12'h000};
         GLYPH_D:     font = {12'h000, 12'h3E0, 12'h330, 12'h318, 12'h318, 12'h318,
                              12'h318, 12'h318, 12'h318, 12'h330, 12'h3E0, 12'h000};
         GLYPH_E:     font = {12'h000, 12'h3FC, 12'h300, 12'h300, 12'h300, 12'h3F0,
                              12'h3F0, 12'h300, 12'h300, 12'h300, 12'h3FC, 12'h000};
         GLYPH_F:     font = {12'h000, 12'h3FC, 12'h300, 12'h300, 12'h300, 12'h3F0,
                              12'h3F0, 12'h300, 12'h300, 12'h300, 12'h300, 12'h000};
         GLYPH_G:     font = {12'h000, 12'h0F8, 12'h18C, 12'h300, 12'h300, 12'h300,
                              12'h33C, 12'h30C, 12'h30C, 12'h18C, 12'h0F8, 12'h000};
         GLYPH_SHARP: font = {12'h000, 12'h198, 12'h198, 12'h7FE, 12'h198, 12'h198,
                              12'h198, 12'h7FE, 12'h198, 12'h198, 12'h198, 12'h000};
         GLYPH_D1:    font = {12'h000, 12'h060, 12'h0E0, 12'h1E0, 12'h060, 12'h060,
                              12'h060, 12'h060, 12'h060, 12'h060, 12'h1F8, 12'h000};
         GLYPH_D2:    font = {12'h000, 12'h0F0, 12'h198, 12'h018, 12'h018, 12'h030,
                              12'h060, 12'h0C0, 12'h180, 12'h300, 12'h3F8, 12'h000};
         GLYPH_D3:    font = {12'h000, 12'h1F0, 12'h018, 12'h018, 12'h018, 12'h0F0,
                              12'h018, 12'h018, 12'h018, 12'h018, 12'h1F0, 12'h000};
         GLYPH_D4:    font = {12'h000, 12'h030, 12'h070, 12'h0F0, 12'h1B0, 12'h330,
                              12'h3F8, 12'h030, 12'h030, 12'h030, 12'h030, 12'h000};
         default:     font = '0;
      endcase
      row_bits_o = (row_i < ROW_W'(FONT_H)) ? GLYPH_W'(font[row_i]) : '0;
   end

endmodule

// File: rtl/note_glyph_renderer.sv
// Renders NUM_GLYPHS font glyphs (fg+bg in one pass, clipped) after a power-on screen wipe.
// Optional NOTE_GLYPH_SCALE2X_EN draws every font bit as a 2x2 pixel block.
module note_glyph_renderer
   import note_glyph_pkg::*;
#(
   parameter int unsigned NUM_GLYPHS = 3,
   parameter int unsigned GLYPH_W    = 12,
   parameter int unsigned GLYPH_H    = 12,
   parameter int unsigned CODE_W     = 4,
   parameter int unsigned X_W        = 8,
   parameter int unsigned Y_W        = 7,
   parameter int unsigned COLOUR_W   = 3,
   parameter int unsigned SCREEN_W   = 160,
   parameter int unsigned SCREEN_H   = 120
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [NUM_GLYPHS*CODE_W-1:0] codes,
   input  logic [X_W-1:0]               x,
   input  logic [Y_W-1:0]               y,
   input  logic [COLOUR_W-1:0]          fg_colour,
   input  logic [COLOUR_W-1:0]          bg_colour,
   output logic                         busy,
   output logic                         done,
   output logic [X_W-1:0]               x_out,
   output logic [Y_W-1:0]               y_out,
   output logic [COLOUR_W-1:0]          colour,
   output logic                         writeEn
);

`ifdef NOTE_GLYPH_SCALE2X_EN
   localparam int unsigned SCALE = 2;
`else
   localparam int unsigned SCALE = 1;
`endif
   localparam int unsigned PITCH  = SCALE * GLYPH_W;
   localparam int unsigned SLOT_W = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
   localparam int unsigned COL_W  = $clog2(GLYPH_W);
   localparam int unsigned ROW_W  = $clog2(GLYPH_H);
   localparam int unsigned XS_W   = X_W + 1;
   localparam int unsigned YS_W   = Y_W + 1;

   state_e state_q, state_d;

   logic [X_W-1:0]               wx_q, wx_d;
   logic [Y_W-1:0]               wy_q, wy_d;
   logic [SLOT_W-1:0]            slot_q, slot_d;
   logic [ROW_W-1:0]             row_q, row_d;
   logic [COL_W-1:0]             col_q, col_d;
   logic [NUM_GLYPHS*CODE_W-1:0] codes_q, codes_d;
   logic [X_W-1:0]               x_q, x_d;
   logic [Y_W-1:0]               y_q, y_d;
   logic [COLOUR_W-1:0]          fg_q, fg_d, bg_q, bg_d;
   logic [X_W-1:0]               xo_q, xo_d;
   logic [Y_W-1:0]               yo_q, yo_d;
   logic [COLOUR_W-1:0]          colour_q, colour_d;
   logic                         we_q, we_d, done_q, done_d;

   logic                         sub_x, sub_y, sub_last;
`ifdef NOTE_GLYPH_SCALE2X_EN
   // bit 0 steps the sub-column, bit 1 the sub-row of the current 2x2 block
   logic [1:0]                   sub_q, sub_d;
   assign sub_x    = sub_q[0];
   assign sub_y    = sub_q[1];
   assign sub_last = &sub_q;
`else
   assign sub_x    = 1'b0;
   assign sub_y    = 1'b0;
   assign sub_last = 1'b1;
`endif

   logic [CODE_W-1:0]  cur_code;
   logic [GLYPH_W-1:0] rom_row;
   logic [COL_W-1:0]   bit_idx;
   logic [XS_W-1:0]    x_sum;
   logic [YS_W-1:0]    y_sum;
   logic               visible;

   assign cur_code = codes_q[slot_q*CODE_W +: CODE_W];
   assign bit_idx  = COL_W'(GLYPH_W - 1) - col_q;
   assign x_sum    = XS_W'(x_q) + XS_W'(slot_q) * XS_W'(PITCH)
                   + XS_W'(col_q) * XS_W'(SCALE) + XS_W'(sub_x);
   assign y_sum    = YS_W'(y_q) + YS_W'(row_q) * YS_W'(SCALE) + YS_W'(sub_y);
   assign visible  = (x_sum < XS_W'(SCREEN_W)) && (y_sum < YS_W'(SCREEN_H));

   glyph_rom #(
      .GLYPH_W (GLYPH_W),
      .GLYPH_H (GLYPH_H),
      .CODE_W  (CODE_W)
   ) u_rom (
      .code_i     (cur_code),
      .row_i      (row_q),
      .row_bits_o (rom_row)
   );

   always_comb begin
      state_d  = state_q;
      wx_d     = wx_q;
      wy_d     = wy_q;
      slot_d   = slot_q;
      row_d    = row_q;
      col_d    = col_q;
      codes_d  = codes_q;
      x_d      = x_q;
      y_d      = y_q;
      fg_d     = fg_q;
      bg_d     = bg_q;
      xo_d     = xo_q;
      yo_d     = yo_q;
      colour_d = colour_q;
      we_d     = 1'b0;
      done_d   = 1'b0;
`ifdef NOTE_GLYPH_SCALE2X_EN
      sub_d    = sub_q;
`endif
      case (state_q)
         S_WIPE: begin
            xo_d     = wx_q;
            yo_d     = wy_q;
            colour_d = '0;
            we_d     = 1'b1;
            if (wx_q == X_W'(SCREEN_W - 1)) begin
               wx_d = '0;
               if (wy_q == Y_W'(SCREEN_H - 1)) begin
                  wy_d    = '0;
                  state_d = S_IDLE;
               end else begin
                  wy_d = wy_q + 1'b1;
               end
            end else begin
               wx_d = wx_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (start) begin
               codes_d = codes;
               x_d     = x;
               y_d     = y;
               fg_d    = fg_colour;
               bg_d    = bg_colour;
               slot_d  = '0;
               row_d   = '0;
               col_d   = '0;
`ifdef NOTE_GLYPH_SCALE2X_EN
               sub_d   = '0;
`endif
               state_d = S_DRAW;
            end
         end
         S_DRAW: begin
            xo_d     = x_sum[X_W-1:0];
            yo_d     = y_sum[Y_W-1:0];
            colour_d = rom_row[bit_idx] ? fg_q : bg_q;
            we_d     = visible;
`ifdef NOTE_GLYPH_SCALE2X_EN
            sub_d    = sub_q + 2'd1;
`endif
            // column innermost, then row, then slot; the last pixel hands over to S_DONE
            if (sub_last) begin
               if (col_q == COL_W'(GLYPH_W - 1)) begin
                  col_d = '0;
                  if (row_q == ROW_W'(GLYPH_H - 1)) begin
                     row_d = '0;
                     if (slot_q == SLOT_W'(NUM_GLYPHS - 1)) begin
                        slot_d  = '0;
                        state_d = S_DONE;
                     end else begin
                        slot_d = slot_q + 1'b1;
                     end
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_WIPE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_WIPE;
         wx_q     <= '0;
         wy_q     <= '0;
         slot_q   <= '0;
         row_q    <= '0;
         col_q    <= '0;
         codes_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         fg_q     <= '0;
         bg_q     <= '0;
         xo_q     <= '0;
         yo_q     <= '0;
         colour_q <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
`ifdef NOTE_GLYPH_SCALE2X_EN
         sub_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wx_q     <= wx_d;
         wy_q     <= wy_d;
         slot_q   <= slot_d;
         row_q    <= row_d;
         col_q    <= col_d;
         codes_q  <= codes_d;
         x_q      <= x_d;
         y_q      <= y_d;
         fg_q     <= fg_d;
         bg_q     <= bg_d;
         xo_q     <= xo_d;
         yo_q     <= yo_d;
         colour_q <= colour_d;
         we_q     <= we_d;
         done_q   <= done_d;
`ifdef NOTE_GLYPH_SCALE2X_EN
         sub_q    <= sub_d;
`endif
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign x_out   = xo_q;
   assign y_out   = yo_q;
   assign colour  = colour_q;
   assign writeEn = we_q;

endmodule

// File: tb/tb_note_glyph_renderer.sv
// Directed bench for note_glyph_renderer: wipe, glyph draw, clipping, start hold, reset, 2x scale.
module tb_note_glyph_renderer;

`ifdef NOTE_GLYPH_SCALE2X_EN
   localparam int SC = 2;
`else
   localparam int SC = 1;
`endif
   localparam int GW = 12;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [11:0] codes;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  fg_colour, bg_colour;
   logic        busy, done, writeEn;
   logic [7:0]  x_out;
   logic [6:0]  y_out;
   logic [2:0]  colour;

   note_glyph_renderer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .codes     (codes),
      .x         (x),
      .y         (y),
      .fg_colour (fg_colour),
      .bg_colour (bg_colour),
      .busy      (busy),
      .done      (done),
      .x_out     (x_out),
      .y_out     (y_out),
      .colour    (colour),
      .writeEn   (writeEn)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [2:0] fb [0:159][0:119];
   int   wr_cnt, oob_cnt, done_cnt, fg_cnt, first_cyc, start_cyc;
   int   first_x, first_y, first_col, last_x, last_y;
   logic [2:0] fg_watch = 3'd7;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (writeEn) begin
         if (wr_cnt == 0) begin
            first_x = x_out; first_y = y_out; first_col = colour; first_cyc = cyc;
         end
         last_x = x_out;
         last_y = y_out;
         wr_cnt++;
         if (x_out >= 160 || y_out >= 120) oob_cnt++;
         else fb[x_out][y_out] = colour;
         if (colour == fg_watch) fg_cnt++;
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      tests_run++;
      if (got != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_mon();
      wr_cnt = 0; oob_cnt = 0; done_cnt = 0; fg_cnt = 0;
      first_x = -1; first_y = -1; first_col = -1; first_cyc = -1;
   endtask

   task automatic fill_fb(input logic [2:0] v);
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++) fb[i][j] = v;
   endtask

   function automatic int count_col(input int x0, input int y0, input int w, input int h,
                                    input logic [2:0] c);
      int n = 0;
      for (int i = x0; i < x0 + w; i++)
         for (int j = y0; j < y0 + h; j++)
            if (i < 160 && j < 120 && fb[i][j] == c) n++;
      return n;
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input int max_cyc, input string tag);
      int n = 0;
      while (busy && n < max_cyc) begin
         tick(1);
         n++;
      end
      check(tag, int'(busy), 0);
   endtask

   task automatic wait_done(input int target, input int max_cyc, input string tag);
      int n = 0;
      while (done_cnt < target && n < max_cyc) begin
         tick(1);
         n++;
      end
      check(tag, done_cnt, target);
   endtask

   task automatic kick(input logic [11:0] c, input logic [7:0] px, input logic [6:0] py,
                       input logic [2:0] f, input logic [2:0] b);
      codes = c; x = px; y = py; fg_colour = f; bg_colour = b;
      fg_watch = f;
      clr_mon();
      start = 1'b1;
      start_cyc = cyc;
   endtask

   initial begin
      int base;
      reset = 1'b1; start = 1'b0; codes = '0; x = '0; y = '0;
      fg_colour = '0; bg_colour = '0;
      clr_mon();
      fill_fb(3'd7);

      // 1: reset values, then the full-screen wipe
      @(posedge clk);
      #1;
      check("rst_we", int'(writeEn), 0);
      check("rst_done", int'(done), 0);
      check("rst_busy", int'(busy), 1);
      check("rst_xy", int'({x_out, y_out}), 0);
      check("rst_col", int'(colour), 0);
      reset = 1'b0;
      clr_mon();
      wait_idle(20000, "wipe_timeout");
      check("wipe_writes", wr_cnt, 19200);
      check("wipe_first", first_x * 1000 + first_y, 0);
      check("wipe_last", last_x * 1000 + last_y, 159119);
      check("wipe_zero_px", count_col(0, 0, 160, 120, 3'd0), 19200);
      check("wipe_oob", oob_cnt, 0);

      // 2: sharp, A, 1 at (10,20)
      tick(2);
      kick({4'd9, 4'd1, 4'd8}, 8'd10, 7'd20, 3'd7, 3'd0);
      tick(1);
      start = 1'b0;
      wait_done(1, 3000, "draw_done");
      tick(5);
      check("draw_done_once", done_cnt, 1);
      check("draw_writes", wr_cnt, 432 * SC * SC);
      check("draw_first", first_x * 1000 + first_y, 10020);
      check("draw_latency", first_cyc - start_cyc, 2);
      base = 10;
      check("sharp_fg", count_col(base, 20, GW * SC, GW * SC, 3'd7), 52 * SC * SC);
      check("sharp_r3_c1", int'(fb[base + SC][20 + 3 * SC]), 7);
      check("sharp_r3_c0", int'(fb[base][20 + 3 * SC]), 0);
      base = 10 + GW * SC;
      check("a_fg", count_col(base, 20, GW * SC, GW * SC, 3'd7), 48 * SC * SC);
      check("a_r5_c2", int'(fb[base + 2 * SC][20 + 5 * SC]), 7);
      check("a_r5_c1", int'(fb[base + SC][20 + 5 * SC]), 0);
      base = 10 + 2 * GW * SC;
      check("d1_fg", count_col(base, 20, GW * SC, GW * SC, 3'd7), 27 * SC * SC);
      check("draw_fg_total", count_col(0, 0, 160, 120, 3'd7), 127 * SC * SC);
      check("draw_busy", int'(busy), 0);

      // 3: clipped draw at the bottom-right corner
      fill_fb(3'd0);
      kick({4'd12, 4'd0, 4'd7}, 8'd150, 7'd115, 3'd5, 3'd2);
      tick(1);
      start = 1'b0;
      wait_done(1, 3000, "clip_done");
      check("clip_writes", wr_cnt, 50);
      check("clip_oob", oob_cnt, 0);
      check("clip_region", count_col(150, 115, 10, 5, 3'd5) + count_col(150, 115, 10, 5, 3'd2), 50);
`ifndef NOTE_GLYPH_SCALE2X_EN
      check("clip_g_fg", count_col(150, 115, 10, 5, 3'd5), 13);
`endif

      // 4: start held high, codes changed mid-draw
      tick(2);
      kick({4'd1, 4'd1, 4'd1}, 8'd40, 7'd60, 3'd6, 3'd1);
      tick(100);
      codes = '0;
      wait_done(1, 3000, "hold_done1");
      check("hold_writes1", wr_cnt, 432 * SC * SC);
      check("hold_fg1", fg_cnt, 144 * SC * SC);
      wait_done(2, 3000, "hold_done2");
      start = 1'b0;
      check("hold_writes2", wr_cnt, 864 * SC * SC);
      check("hold_fg2", fg_cnt, 144 * SC * SC);
      tick(50);
      check("hold_no_third", done_cnt, 2);
      check("hold_writes_end", wr_cnt, 864 * SC * SC);
      check("hold_busy", int'(busy), 0);

      // 5: reset in the middle of a draw
      kick({4'd1, 4'd1, 4'd1}, 8'd0, 7'd0, 3'd7, 3'd3);
      tick(1);
      start = 1'b0;
      tick(50);
      check("mid_busy", int'(busy), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mrst_we", int'(writeEn), 0);
      check("mrst_busy", int'(busy), 1);
      check("mrst_done", int'(done), 0);
      reset = 1'b0;
      clr_mon();
      fill_fb(3'd7);
      wait_idle(20000, "rewipe_timeout");
      check("rewipe_first", first_x * 1000 + first_y, 0);
      check("rewipe_first_col", first_col, 0);
      check("rewipe_writes", wr_cnt, 19200);
      check("rewipe_zero_px", count_col(0, 0, 160, 120, 3'd0), 19200);

`ifdef NOTE_GLYPH_SCALE2X_EN
      // 6: one A at (0,0) drawn as 2x2 blocks
      begin
         int bad = 0;
         tick(2);
         kick({4'd0, 4'd0, 4'd1}, 8'd0, 7'd0, 3'd7, 3'd0);
         tick(1);
         start = 1'b0;
         wait_done(1, 3000, "x2_done");
         check("x2_writes", wr_cnt, 1728);
         check("x2_a_fg", count_col(0, 0, 24, 24, 3'd7), 192);
         for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++)
               if (fb[2*c+1][2*r] != fb[2*c][2*r] || fb[2*c][2*r+1] != fb[2*c][2*r] ||
                   fb[2*c+1][2*r+1] != fb[2*c][2*r]) bad++;
         check("x2_blocks", bad, 0);
         check("x2_r5_c2", int'(fb[4][10]), 7);
         check("x2_r5_c1", int'(fb[3][11]), 0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
